// File: rtl/pu_n_acc.sv
// N-lane processing unit: per-lane pass/approx transform, saturating adder tree,
// optional ACC_LEN-beat saturating accumulation, 2-stage valid/ready pipeline.
module pu_n_acc #(
    parameter int unsigned XLEN    = 5,
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned ACC_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*XLEN-1:0]   nums,
    input  logic [NUM_IN-1:0]        lane_mode,
    input  logic                     acc_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          result,
    output logic                     sat_flag,
    output logic                     frame_last
);
    localparam int unsigned SW = XLEN + $clog2(NUM_IN);
    localparam int unsigned CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [XLEN-1:0] MAXV = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    logic                         en, accept;
    logic [NUM_IN-1:0][XLEN-1:0]  t_w;
    logic [SW-1:0]                sum_w;
    logic                         sat_w;
    logic [XLEN-1:0]              sat_sum_w;
    logic [XLEN:0]                acc_sum_w;
    logic                         acc_ovf_w;
    logic [XLEN-1:0]              acc_sat_w;

    logic                         s1_valid_q, s1_acc_q;
    logic [NUM_IN-1:0][XLEN-1:0]  s1_t_q;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [XLEN-1:0]              acc_q, acc_d;
    logic                         sticky_q, sticky_d;
    logic                         out_valid_q, out_valid_d;
    logic [XLEN-1:0]              result_q, result_d;
    logic                         sat_q, sat_d;
    logic                         last_q, last_d;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en && !rst;
    assign accept   = in_valid && in_ready;

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign sat_flag   = sat_q;
    assign frame_last = last_q;

    always_comb begin
        t_w = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (lane_mode[i])
                t_w[i] = {1'b1, {(XLEN-3){1'b0}}, nums[i*XLEN + XLEN-2], nums[i*XLEN + XLEN-3]};
            else
                t_w[i] = nums[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        sum_w = '0;
        for (int unsigned i = 0; i < NUM_IN; i++)
            sum_w = sum_w + SW'(s1_t_q[i]);
        sat_w     = sum_w > SW'(MAXV);
        sat_sum_w = sat_w ? MAXV : sum_w[XLEN-1:0];
        acc_sum_w = {1'b0, acc_q} + {1'b0, sat_sum_w};
        acc_ovf_w = acc_sum_w[XLEN];
        acc_sat_w = acc_ovf_w ? MAXV : acc_sum_w[XLEN-1:0];
    end

    // S2 only advances with the pipeline; a bubble or mid-frame beat drops out_valid.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sat_d       = sat_q;
        last_d      = last_q;
        if (en) begin
            out_valid_d = 1'b0;
            if (s1_valid_q) begin
                if (!s1_acc_q) begin
                    result_d    = sat_sum_w;
                    sat_d       = sat_w;
                    last_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                end else if (state_q == IDLE) begin
                    acc_d    = sat_sum_w;
                    cnt_d    = CW'(1);
                    sticky_d = sat_w;
                    state_d  = ACCUM;
                end else if (cnt_q == CNT_LAST) begin
                    result_d    = acc_sat_w;
                    sat_d       = sticky_q | sat_w | acc_ovf_w;
                    last_d      = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                end else begin
                    acc_d    = acc_sat_w;
                    sticky_d = sticky_q | sat_w | acc_ovf_w;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_acc_q    <= 1'b0;
            s1_t_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            if (en) begin
                s1_valid_q <= accept;
                s1_acc_q   <= accept && acc_en;
                if (accept)
                    s1_t_q <= t_w;
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
            last_q      <= last_d;
        end
    end
endmodule

// File: tb/tb_pu_n_acc.sv
// Self-checking bench for pu_n_acc: frame-level reference model with a result
// queue, directed literal cases, then randomized traffic with stalls and resets.
module tb_pu_n_acc;
    localparam int XLEN = 5;
    localparam int NUM_IN = 4;
    localparam int ACC_LEN = 4;
    localparam int MAXV = (1 << XLEN) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_IN*XLEN-1:0] nums;
    logic [NUM_IN-1:0]      lane_mode;
    logic                   acc_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        result;
    logic                   sat_flag;
    logic                   frame_last;

    pu_n_acc #(.XLEN(XLEN), .NUM_IN(NUM_IN), .ACC_LEN(ACC_LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .nums(nums), .lane_mode(lane_mode), .acc_en(acc_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .sat_flag(sat_flag), .frame_last(frame_last)
    );

    always #5 clk = ~clk;

    typedef struct { int r; int s; int l; } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    int last_res, last_sat, last_last;
    int m_cnt = 0, m_acc = 0, m_sticky = 0;
    logic prev_rst = 1'b1, prev_stall = 1'b0;
    int prev_res, prev_sat, prev_last;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: whole frames computed from the arithmetic rules, outputs queued in order.
    task automatic model_accept(input logic [NUM_IN*XLEN-1:0] n, input logic [NUM_IN-1:0] m, input logic a);
        int sum = 0, v, t, ss, sat, s;
        exp_t e;
        for (int i = 0; i < NUM_IN; i++) begin
            v = (int'(n) >> (i*XLEN)) & MAXV;
            t = m[i] ? ((1 << (XLEN-1)) + ((v >> (XLEN-3)) & 3)) : v;
            sum += t;
        end
        sat = (sum > MAXV) ? 1 : 0;
        ss  = sat ? MAXV : sum;
        if (!a) begin
            m_cnt = 0; m_acc = 0; m_sticky = 0;
            e.r = ss; e.s = sat; e.l = 0;
            exp_q.push_back(e);
        end else if (m_cnt == 0) begin
            m_acc = ss; m_sticky = sat; m_cnt = 1;
        end else begin
            s = m_acc + ss;
            m_sticky = m_sticky | sat | ((s > MAXV) ? 1 : 0);
            m_acc = (s > MAXV) ? MAXV : s;
            if (m_cnt == ACC_LEN-1) begin
                e.r = m_acc; e.s = m_sticky; e.l = 1;
                exp_q.push_back(e);
                m_cnt = 0; m_acc = 0; m_sticky = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", int'(in_ready), 0);
            exp_q.delete();
            m_cnt = 0; m_acc = 0; m_sticky = 0;
        end else begin
            if (prev_rst) begin
                chk("post_rst_valid", int'(out_valid), 0);
                chk("post_rst_result", int'(result), 0);
                chk("post_rst_sat", int'(sat_flag), 0);
                chk("post_rst_last", int'(frame_last), 0);
            end
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_result", int'(result), prev_res);
                chk("stall_sat", int'(sat_flag), prev_sat);
                chk("stall_last", int'(frame_last), prev_last);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", int'(in_ready), 0);
            if (!out_valid) chk("idle_in_ready", int'(in_ready), 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("result", int'(result), exp_q[0].r);
                    chk("sat_flag", int'(sat_flag), exp_q[0].s);
                    chk("frame_last", int'(frame_last), exp_q[0].l);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                        last_res = result; last_sat = sat_flag; last_last = frame_last;
                    end
                end
            end
            if (in_valid && in_ready) model_accept(nums, lane_mode, acc_en);
        end
        prev_rst   = rst;
        prev_stall = out_valid && !out_ready && !rst;
        prev_res   = result; prev_sat = sat_flag; prev_last = frame_last;
    end

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic send(input logic [NUM_IN*XLEN-1:0] n, input logic [NUM_IN-1:0] m, input logic a);
        int k = 0;
        in_valid = 1'b1; nums = n; lane_mode = m; acc_en = a;
        @(negedge clk);
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int k = 0;
        while (n_out < target && k < 40) begin @(posedge clk); k++; end
        if (n_out < target) chk("out_timeout", n_out, target);
        #1;
    endtask

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; nums = '0; lane_mode = '0; acc_en = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Pass-through sum with latency check
        base = n_out;
        send({5'd6, 5'd5, 5'd4, 5'd3}, 4'b0000, 1'b0);
        @(negedge clk); chk("lat_cycle1", int'(out_valid), 0);
        @(negedge clk); chk("lat_cycle2", int'(out_valid), 1);
        chk("t1_result", int'(result), 18);
        @(posedge clk); #1;
        wait_out(base + 1);

        // Approx transform, saturating and not
        send({4{5'b01100}}, 4'b1111, 1'b0);
        wait_out(base + 2);
        chk("t2a_result", last_res, 31); chk("t2a_sat", last_sat, 1);
        send({5'd0, 5'd0, 5'd0, 5'b01100}, 4'b0001, 1'b0);
        wait_out(base + 3);
        chk("t2b_result", last_res, 19); chk("t2b_sat", last_sat, 0);

        // Full 4-beat frame, no saturation
        for (int i = 0; i < ACC_LEN; i++) send({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 1'b1);
        wait_out(base + 4);
        repeat (3) @(posedge clk); #1;
        chk("t3_count", n_out, base + 4);
        chk("t3_result", last_res, 16); chk("t3_last", last_last, 1); chk("t3_sat", last_sat, 0);

        // Saturating frame, then aborted frame, then fresh frame
        for (int i = 0; i < ACC_LEN; i++) send({5'd1, 5'd2, 5'd3, 5'd4}, 4'b0000, 1'b1);
        wait_out(base + 5);
        chk("t4a_result", last_res, 31); chk("t4a_sat", last_sat, 1); chk("t4a_last", last_last, 1);
        send({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 1'b1);
        send({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 1'b1);
        send({5'd0, 5'd1, 5'd2, 5'd4}, 4'b0000, 1'b0);
        wait_out(base + 6);
        repeat (3) @(posedge clk); #1;
        chk("t4b_count", n_out, base + 6);
        chk("t4b_result", last_res, 7); chk("t4b_last", last_last, 0);
        for (int i = 0; i < ACC_LEN; i++) send({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 1'b1);
        wait_out(base + 7);
        chk("t4c_result", last_res, 16); chk("t4c_last", last_last, 1);

        // Downstream stall with two results pending
        out_ready = 1'b0;
        send({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 1'b0);
        send({5'd2, 5'd2, 5'd2, 5'd2}, 4'b0000, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("t5_in_ready", int'(in_ready), 0);
            chk("t5_result", int'(result), 4);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_out(base + 9);
        chk("t5_second", last_res, 8);

        // Reset mid-frame
        send({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 1'b1);
        send({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("t6_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        base = n_out;
        for (int i = 0; i < ACC_LEN; i++) send({5'd0, 5'd0, 5'd1, 5'd1}, 4'b0000, 1'b1);
        wait_out(base + 1);
        chk("t6_result", last_res, 8); chk("t6_last", last_last, 1);

        // Randomized traffic with stalls and occasional resets
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            nums      = NUM_IN*XLEN'($urandom);
            lane_mode = NUM_IN'($urandom);
            acc_en    = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            rst       = ($urandom_range(99) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
